upg_stream_loader: RTL

- Sequencer that drives the UART programming port of instruction and data memory.
- Consumes a byte stream from the UART receiver and packs it little-endian into 32-bit words.
- Writes instruction memory first, then data memory, then raises upg_done_o so the memories hand control back to the CPU.
- Enforces length limits and an inter-byte timeout.

---
 rtl/upg_stream_loader_pkg.sv | 25 ++
 rtl/upg_byte_packer.sv | 36 +++
 rtl/upg_stream_loader.sv | 101 ++++++++++
 3 files changed

// File: rtl/upg_stream_loader_pkg.sv
// upg_stream_loader_pkg: shared states, region select bits and byte-lane helper for the UART loader
package upg_stream_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_I_LEN,
        S_I_DATA,
        S_I_WR,
        S_D_LEN,
        S_D_DATA,
        S_D_WR,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic REGION_IMEM = 1'b0;
    localparam logic REGION_DMEM = 1'b1;

    // Little-endian: byte k of a word lands in bits [8k+7:8k].
    function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] k, input logic [7:0] b);
        put_lane = w;
        put_lane[{k, 3'b000} +: 8] = b;
    endfunction

endpackage

// File: rtl/upg_byte_packer.sv
// upg_byte_packer: assembles four accepted bytes into a little-endian word and flags the 4th byte
module upg_byte_packer
    import upg_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    // word_o already includes the byte being accepted, so the full word is usable in the same cycle.
    assign word_o       = put_lane(word_q, cnt_q, byte_i);
    assign word_valid_o = valid_i && cnt_q == 2'd3;

    always_comb begin
        cnt_d  = clr_i ? 2'd0 : valid_i ? cnt_q + 2'd1 : cnt_q;
        word_d = valid_i ? word_o : word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/upg_stream_loader.sv
// upg_stream_loader: UART byte stream to imem/dmem programming port sequencer
module upg_stream_loader
    import upg_stream_loader_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W:0]   waddr_q, waddr_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [31:0]       word;
    logic              acc, wv, tmo, is_len, is_data, is_d, too_big, last;

    assign is_len     = state_q == S_I_LEN || state_q == S_D_LEN;
    assign is_data    = state_q == S_I_DATA || state_q == S_D_DATA;
    assign is_d       = state_q == S_D_LEN || state_q == S_D_DATA || state_q == S_D_WR;
    assign rx_ready_o = is_len || is_data;
    assign upg_wen_o  = state_q == S_I_WR || state_q == S_D_WR;
    assign upg_done_o = state_q == S_DONE;
    assign err_o      = state_q == S_ERR;
    assign busy_o     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign acc        = rx_valid_i && rx_ready_o;
    assign tmo        = tmo_q == CNT_W'(TIMEOUT_CYC - 1);
    assign too_big    = {1'b0, word} > (33'd1 << ADDR_W);
    // Counter is one bit wider than the address so N = 2^ADDR_W terminates without wrapping.
    assign last       = waddr_q + (ADDR_W+1)'(1) == n_q;

    upg_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (!rx_ready_o),
        .valid_i      (acc),
        .byte_i       (rx_data_i),
        .word_o       (word),
        .word_valid_o (wv)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: state_d = start_i ? S_I_LEN : state_q;
            S_I_LEN, S_D_LEN:
                if (wv)
                    state_d = too_big ? S_ERR :
                              word == 32'd0 ? (is_d ? S_DONE : S_D_LEN) :
                              (is_d ? S_D_DATA : S_I_DATA);
                else if (tmo)
                    state_d = S_ERR;
            S_I_DATA, S_D_DATA: state_d = wv ? (is_d ? S_D_WR : S_I_WR) : tmo ? S_ERR : state_q;
            S_I_WR, S_D_WR: state_d = last ? (is_d ? S_DONE : S_D_LEN) : (is_d ? S_D_DATA : S_I_DATA);
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tmo_d   = (!rx_ready_o || acc || state_d != state_q) ? '0 : tmo_q + CNT_W'(1);
        waddr_d = (is_len && wv) ? '0 : upg_wen_o ? waddr_q + (ADDR_W+1)'(1) : waddr_q;
        n_d     = (is_len && wv) ? word[ADDR_W:0] : n_q;
        adr_d   = (is_data && wv) ? {is_d ? REGION_DMEM : REGION_IMEM, waddr_q[ADDR_W-1:0]} : adr_q;
        dat_d   = (is_data && wv) ? word : dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            waddr_q <= '0;
            n_q     <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            waddr_q <= waddr_d;
            n_q     <= n_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

endmodule
